// File: rtl/slow_clock_div.sv
// Runtime-programmable slow clock: 50% duty slow_clk plus a rising-edge tick strobe.
// Define SLOWCLK_IMMEDIATE_LOAD_EN to apply div_load at once instead of at the next toggle.
module slow_clock_div #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 10
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_pending,
    output logic             div_err,
    output logic             slow_clk,
    output logic             tick
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             load_ok;
    logic             terminal;
    logic             advance;

    assign load_ok  = div_load && (div_in != '0);
    assign terminal = (counter_q == (half_q - ONE));
    assign advance  = !sync_clr && enable && terminal;

`ifdef SLOWCLK_IMMEDIATE_LOAD_EN

    assign div_pending = 1'b0;

    always_comb begin
        counter_d = counter_q;
        half_d    = half_q;
        slow_d    = slow_q;
        tick_d    = 1'b0;
        err_d     = div_load && (div_in == '0);
        if (sync_clr) begin
            counter_d = '0;
            slow_d    = 1'b0;
        end else if (enable) begin
            if (terminal) begin
                counter_d = '0;
                slow_d    = ~slow_q;
                tick_d    = ~slow_q;
            end else begin
                counter_d = counter_q + ONE;
            end
        end
        // A valid load restarts the half-period but never toggles slow_clk itself.
        if (load_ok) begin
            half_d    = div_in;
            counter_d = '0;
            tick_d    = 1'b0;
            slow_d    = sync_clr ? 1'b0 : slow_q;
        end
    end

`else

    logic [CNT_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;

    assign div_pending = pend_q;

    always_comb begin
        counter_d = counter_q;
        half_d    = half_q;
        slow_d    = slow_q;
        tick_d    = 1'b0;
        err_d     = div_load && (div_in == '0);
        pval_d    = pval_q;
        pend_d    = pend_q;
        if (sync_clr) begin
            counter_d = '0;
            slow_d    = 1'b0;
        end else if (enable) begin
            if (terminal) begin
                counter_d = '0;
                slow_d    = ~slow_q;
                tick_d    = ~slow_q;
            end else begin
                counter_d = counter_q + ONE;
            end
        end
        // The boundary consumes the old pending value; a same-cycle load re-arms.
        if (advance && pend_q) begin
            half_d = pval_q;
            pend_d = 1'b0;
        end
        if (load_ok) begin
            pval_d = div_in;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pval_q <= '0;
            pend_q <= 1'b0;
        end else begin
            pval_q <= pval_d;
            pend_q <= pend_d;
        end
    end

`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            half_q    <= HALF_RST;
            slow_q    <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            half_q    <= half_d;
            slow_q    <= slow_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

    assign slow_clk = slow_q;
    assign tick     = tick_q;
    assign div_err  = err_q;

endmodule

// File: tb/tb_slow_clock_div.sv
// Self-checking bench for slow_clock_div: vector tables plus hand sequences, scored
// through an expected queue of {slow_clk, tick, div_pending, div_err}.
module tb_slow_clock_div;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        sync_clr = 1'b0;
  logic        div_load = 1'b0;
  logic [15:0] div_in = '0;
  logic        div_pending;
  logic        div_err;
  logic        slow_clk;
  logic        tick;

  slow_clock_div #(.CNT_W(16), .DEFAULT_HALF(10)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .sync_clr    (sync_clr),
    .div_in      (div_in),
    .div_load    (div_load),
    .div_pending (div_pending),
    .div_err     (div_err),
    .slow_clk    (slow_clk),
    .tick        (tick)
  );

  // clock/reset block
  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    bit          rst;
    bit          sc;
    bit          en;
    bit          ld;
    logic [15:0] din;
    logic [3:0]  exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         n_pass = 0;
  int         n_total = 0;

  task automatic add(input string nm, input bit r, input bit sc, input bit en,
                     input bit ld, input int din, input logic [3:0] e, input int n = 1);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.name = nm;
      v.rst  = r && (i == 0);
      v.sc   = sc;
      v.en   = en;
      v.ld   = ld;
      v.din  = din[15:0];
      v.exp  = e;
      vecs.push_back(v);
    end
  endtask

  // scoreboard
  task automatic check(input string nm, input logic [3:0] act);
    logic [3:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got slow/tick/pend/err=%b", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act === e) n_pass++;
      else $display("FAIL %s: got slow/tick/pend/err=%b expected %b", nm, act, e);
    end
  endtask

  // driver tasks
  task automatic apply_reset(input string nm);
    @(negedge clk_in);
    reset    = 1'b1;
    sync_clr = 1'b0;
    enable   = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    exp_q.push_back(4'b0000);
    #1 check({nm, ":reset"}, {slow_clk, tick, div_pending, div_err});
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic cycle(input string nm, input bit sc, input bit en, input bit ld,
                       input logic [15:0] din, input logic [3:0] e);
    @(negedge clk_in);
    sync_clr = sc;
    enable   = en;
    div_load = ld;
    div_in   = din;
    exp_q.push_back(e);
    @(posedge clk_in);
    #1 check(nm, {slow_clk, tick, div_pending, div_err});
  endtask

  initial begin
    logic [3:0] e;

    // enable hold at counter=4 delays the first rise from edge 10 to edge 15
    add("enable_hold", 1, 0, 1, 0, 0, 4'b0000, 4);
    add("enable_hold", 0, 0, 0, 0, 0, 4'b0000, 5);
    add("enable_hold", 0, 0, 1, 0, 0, 4'b0000, 5);
    add("enable_hold", 0, 0, 1, 0, 0, 4'b1100);
`ifdef SLOWCLK_IMMEDIATE_LOAD_EN
    add("imm_load", 1, 0, 1, 0, 0, 4'b0000, 5);
    add("imm_load", 0, 0, 1, 1, 2, 4'b0000);
    add("imm_load", 0, 0, 1, 0, 0, 4'b0000);
    add("imm_load", 0, 0, 1, 0, 0, 4'b1100);
    add("imm_load", 0, 0, 1, 0, 0, 4'b1000);
    add("imm_load", 0, 0, 1, 0, 0, 4'b0000);
    add("imm_zero", 1, 0, 1, 1, 0, 4'b0001);
    add("imm_zero", 0, 0, 1, 0, 0, 4'b0000, 8);
    add("imm_zero", 0, 0, 1, 0, 0, 4'b1100);
`else
    add("deferred", 1, 0, 1, 0, 0, 4'b0000, 2);
    add("deferred", 0, 0, 1, 1, 3, 4'b0010);
    add("deferred", 0, 0, 1, 0, 0, 4'b0010, 6);
    add("deferred", 0, 0, 1, 0, 0, 4'b1100);
    add("deferred", 0, 0, 1, 0, 0, 4'b1000, 2);
    add("deferred", 0, 0, 1, 0, 0, 4'b0000, 3);
    add("deferred", 0, 0, 1, 0, 0, 4'b1100);
    add("deferred", 0, 0, 1, 0, 0, 4'b1000, 2);
    add("deferred", 0, 0, 1, 0, 0, 4'b0000);

    add("zero_last_wins", 1, 0, 1, 1, 0, 4'b0001);
    add("zero_last_wins", 0, 0, 1, 0, 0, 4'b0000);
    add("zero_last_wins", 0, 0, 1, 1, 4, 4'b0010);
    add("zero_last_wins", 0, 0, 1, 1, 6, 4'b0010);
    add("zero_last_wins", 0, 0, 1, 0, 0, 4'b0010, 5);
    add("zero_last_wins", 0, 0, 1, 0, 0, 4'b1100);
    add("zero_last_wins", 0, 0, 1, 0, 0, 4'b1000, 5);
    add("zero_last_wins", 0, 0, 1, 0, 0, 4'b0000);

    add("load_on_terminal", 1, 0, 1, 0, 0, 4'b0000, 9);
    add("load_on_terminal", 0, 0, 1, 1, 2, 4'b1110);
    add("load_on_terminal", 0, 0, 1, 0, 0, 4'b1010, 9);
    add("load_on_terminal", 0, 0, 1, 0, 0, 4'b0000, 2);
    add("load_on_terminal", 0, 0, 1, 0, 0, 4'b1100);

    add("load_term_pending", 1, 0, 1, 0, 0, 4'b0000, 4);
    add("load_term_pending", 0, 0, 1, 1, 3, 4'b0010);
    add("load_term_pending", 0, 0, 1, 0, 0, 4'b0010, 4);
    add("load_term_pending", 0, 0, 1, 1, 2, 4'b1110);
    add("load_term_pending", 0, 0, 1, 0, 0, 4'b1010, 2);
    add("load_term_pending", 0, 0, 1, 0, 0, 4'b0000, 2);
    add("load_term_pending", 0, 0, 1, 0, 0, 4'b1100);
    add("load_term_pending", 0, 0, 1, 0, 0, 4'b1000);
    add("load_term_pending", 0, 0, 1, 0, 0, 4'b0000);

    add("sync_clr", 1, 0, 1, 0, 0, 4'b0000, 9);
    add("sync_clr", 0, 0, 1, 0, 0, 4'b1100);
    add("sync_clr", 0, 0, 1, 0, 0, 4'b1000);
    add("sync_clr", 0, 0, 1, 1, 5, 4'b1010);
    add("sync_clr", 0, 0, 1, 0, 0, 4'b1010, 5);
    add("sync_clr", 0, 1, 1, 0, 0, 4'b0010);
    add("sync_clr", 0, 0, 1, 0, 0, 4'b0010, 9);
    add("sync_clr", 0, 0, 1, 0, 0, 4'b1100);
    add("sync_clr", 0, 0, 1, 0, 0, 4'b1000, 4);
    add("sync_clr", 0, 0, 1, 0, 0, 4'b0000);

    add("half_one", 1, 0, 1, 1, 1, 4'b0010);
    add("half_one", 0, 0, 1, 0, 0, 4'b0010, 8);
    add("half_one", 0, 0, 1, 0, 0, 4'b1100);
    add("half_one", 0, 0, 1, 0, 0, 4'b0000);
    add("half_one", 0, 0, 1, 0, 0, 4'b1100);
    add("half_one", 0, 0, 1, 0, 0, 4'b0000);
`endif

    // default run: rises at edges 10 and 30, falls at 20
    apply_reset("default_run");
    for (int k = 1; k <= 30; k++) begin
      e[3] = ((k / 10) % 2) == 1;
      e[2] = (k == 10) || (k == 30);
      e[1] = 1'b0;
      e[0] = 1'b0;
      cycle($sformatf("default_run[%0d]", k), 1'b0, 1'b1, 1'b0, 16'd0, e);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) apply_reset(vecs[i].name);
      cycle($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].sc, vecs[i].en,
            vecs[i].ld, vecs[i].din, vecs[i].exp);
    end

`ifndef SLOWCLK_IMMEDIATE_LOAD_EN
    // async reset in the middle of a cycle drops the pending load and restores half=10
    apply_reset("async_reset");
    cycle("async_reset_pre", 1'b0, 1'b1, 1'b0, 16'd0, 4'b0000);
    cycle("async_reset_pre", 1'b0, 1'b1, 1'b1, 16'd7, 4'b0010);
    #3;
    div_load = 1'b0;
    enable   = 1'b0;
    reset    = 1'b1;
    exp_q.push_back(4'b0000);
    #1 check("async_reset_mid", {slow_clk, tick, div_pending, div_err});
    @(negedge clk_in);
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      e = (k < 10) ? 4'b0000 : ((k == 10) ? 4'b1100 : 4'b1000);
      cycle($sformatf("async_reset_post[%0d]", k), 1'b0, 1'b1, 1'b0, 16'd0, e);
    end
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
